// File: rtl/elastic_pipe_pkg.sv
// Shared types and helpers for the elastic delay pipeline.
//   lane_t : one lane of payload at the default lane width.
//   occ_w  : width of an occupancy counter able to hold 0..depth.
package elastic_pipe_pkg;

    localparam int unsigned LANE_WIDTH = 8;

    typedef logic [LANE_WIDTH-1:0] lane_t;

    // Bits needed to count from 0 up to and including depth.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data register.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous clear of the valid bit
//   up_valid, up_data   beat offered by the upstream stage (or producer)
//   down_rdy            ready of the downstream stage (or consumer)
//   rdy                 this stage can take a beat this cycle
//   valid, data         registered contents of this stage
module elastic_pipe_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          down_rdy,
    output logic          rdy,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          v_q;
    logic          v_d;
    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;

    // An empty stage always loads, which is what lets bubbles collapse.
    assign rdy   = !v_q | down_rdy;
    assign valid = v_q;
    assign data  = d_q;

    // Next-state: flush clears valid; otherwise load when ready, else hold.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy) begin
            v_d = up_valid;
            // Data only moves with a real beat so out_data keeps its last value.
            if (up_valid) begin
                d_d = up_data;
            end else begin
                d_d = d_q;
            end
        end else begin
            v_d = v_q;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/elastic_delay_pipe.sv
// Multi-lane elastic register pipeline with valid/ready handshake,
// bubble collapsing, flush and an occupancy count.
// Optional feature macro: ELASTIC_PIPE_BITREV_EN -- when defined every lane of
// out_data is bit-reversed at the output (lane order unchanged).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous clear of every stage
//   in_valid/in_ready   producer handshake, in_data lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready consumer handshake, out_data lane k at [k*WIDTH +: WIDTH]
//   occupancy           registered count of valid stages (0..DEPTH)
module elastic_delay_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [occ_w(DEPTH)-1:0]      occupancy
);

    localparam int unsigned DW    = CHANNELS * WIDTH;
    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] rdy_s;
    logic [DW-1:0]    d_s [DEPTH];
    logic [DW-1:0]    last_data_s;

    logic             in_fire_s;
    logic             out_fire_s;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Stage 0 faces the producer; stage DEPTH-1 faces the consumer. The ready
    // chain runs combinationally from the consumer back to the producer.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          up_valid_s;
        logic [DW-1:0] up_data_s;
        logic          down_rdy_s;

        if (i == 0) begin : g_first
            assign up_valid_s = in_valid;
            assign up_data_s  = in_data;
        end else begin : g_mid
            assign up_valid_s = v_s[i-1];
            assign up_data_s  = d_s[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_rdy_s = out_ready;
        end else begin : g_inner
            assign down_rdy_s = rdy_s[i+1];
        end

        elastic_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .down_rdy (down_rdy_s),
            .rdy      (rdy_s[i]),
            .valid    (v_s[i]),
            .data     (d_s[i])
        );
    end

    assign in_ready    = rdy_s[0] & !flush;
    assign out_valid   = v_s[DEPTH-1];
    assign last_data_s = d_s[DEPTH-1];

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

`ifdef ELASTIC_PIPE_BITREV_EN
    // Per-lane bit reversal; purely combinational so latency is unchanged.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            assign out_data[k*WIDTH + j] = last_data_s[k*WIDTH + (WIDTH - 1 - j)];
        end
    end
`else
    assign out_data = last_data_s;
`endif

    // Occupancy next-state: flush empties; otherwise +in fire -out fire.
    // It tracks the number of set valid bits, so it cannot exceed DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(in_fire_s) - OCC_W'(out_fire_s);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// Directed self-checking bench for elastic_delay_pipe (WIDTH=8, CHANNELS=4, DEPTH=3).
module tb_elastic_delay_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks;
    int errors;

    elastic_delay_pipe #(
        .WIDTH    (8),
        .CHANNELS (4),
        .DEPTH    (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int got;
        logic fire;

        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // 1. Reset state, then reset asserted with two beats in flight.
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_occ", {30'b0, occupancy}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = rep(8'hAA);
        tick();
        in_data  = rep(8'hBB);
        tick();
        in_valid = 1'b0;
        check("pre_rst_occ", {30'b0, occupancy}, 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_occ", {30'b0, occupancy}, 32'd0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rst_no_emerge", {31'b0, out_valid}, 32'd0);
        end

        // 2. Back-to-back streaming of 8 beats with the consumer always ready.
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data  = rep(8'(c));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 0) check("str_occ_first", {30'b0, occupancy}, 32'd1);
            if (c >= 2 && c <= 9) begin
                check("str_out_valid", {31'b0, out_valid}, 32'd1);
                check("str_out_data", out_data, rep(8'(c - 2)));
            end
            if (c >= 2 && c <= 7) check("str_occ", {30'b0, occupancy}, 32'd3);
            if (c == 10) begin
                check("str_end_valid", {31'b0, out_valid}, 32'd0);
                check("str_end_occ", {30'b0, occupancy}, 32'd0);
            end
        end

        // 3. Backpressure: 5 beats offered while the consumer stalls.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = rep(8'(8'h10 + idx));
            #1;
            if (c == 3) check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
            fire = in_ready;
            tick();
            if (fire) idx++;
        end
        check("bp_accepted", idx, 32'd3);
        check("bp_occ", {30'b0, occupancy}, 32'd3);
        check("bp_hold_data", out_data, rep(8'h10));
        out_ready = 1'b1;
        #1;
        check("bp_full_ready", {31'b0, in_ready}, 32'd1);
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            in_valid = (idx < 5);
            in_data  = rep(8'(8'h10 + idx));
            #1;
            fire = in_valid && in_ready;
            if (out_valid) begin
                check("bp_drain_data", out_data, rep(8'(8'h10 + got)));
                got++;
            end
            tick();
            if (fire) idx++;
        end
        in_valid = 1'b0;
        check("bp_drained", got, 32'd5);
        tick();
        check("bp_empty_valid", {31'b0, out_valid}, 32'd0);
        check("bp_empty_occ", {30'b0, occupancy}, 32'd0);

        // 4. Bubble collapse: A waits at the output, B packs behind it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rep(8'h21);
        tick();
        in_valid = 1'b0;
        check("bub_occ1", {30'b0, occupancy}, 32'd1);
        for (int c = 0; c < 4; c++) tick();
        check("bub_a_valid", {31'b0, out_valid}, 32'd1);
        check("bub_a_data", out_data, rep(8'h21));
        in_valid = 1'b1;
        in_data  = rep(8'h22);
        #1;
        check("bub_b_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bub_occ2", {30'b0, occupancy}, 32'd2);
        check("bub_a_held", out_data, rep(8'h21));

        // 5. Flush with a beat offered and two beats stored.
        in_valid = 1'b1;
        in_data  = rep(8'h33);
        flush    = 1'b1;
        #1;
        check("fl_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", {30'b0, occupancy}, 32'd0);
        check("fl_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("fl_no_emerge", {31'b0, out_valid}, 32'd0);

        // 6. Lane ordering and optional bit reversal.
        in_valid = 1'b1;
        in_data  = {8'hF0, 8'h55, 8'h3C, 8'h01};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("lane_valid", {31'b0, out_valid}, 32'd1);
`ifdef ELASTIC_PIPE_BITREV_EN
        check("lane_data", out_data, {8'h0F, 8'hAA, 8'h3C, 8'h80});
`else
        check("lane_data", out_data, {8'hF0, 8'h55, 8'h3C, 8'h01});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
